// File: rtl/calc_pkg.sv
// ============================================================================
// calc_pkg: shared opcode and state encodings for the sequential calculator.
// Rev 1.0
// ============================================================================
`default_nettype none

package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/calc_iter_unit.sv
// ============================================================================
// calc_iter_unit: shared shift-add multiplier / restoring divider, one bit per step.
// Rev 1.0
// ============================================================================
`default_nettype none

module calc_iter_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic                 load,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 last,
    output logic [2*WIDTH-1:0]   prod_next,
    output logic [WIDTH-1:0]     quot_next,
    output logic [WIDTH-1:0]     rem_next
);

    // mul: hi=partial product, lo=multiplier shifting out, opnd=multiplicand
    // div: hi=partial remainder, lo=dividend shifting out / quotient in, opnd=divisor
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] add_in;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   div_diff;
    logic             fits;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;
    logic [WIDTH-1:0] nxt_hi;
    logic [WIDTH-1:0] nxt_lo;

    assign add_in   = lo[0] ? opnd : '0;
    assign mul_sum  = {1'b0, hi} + {1'b0, add_in};
    assign mul_hi   = mul_sum[WIDTH:1];
    assign mul_lo   = {mul_sum[0], lo[WIDTH-1:1]};

    // Partial remainder stays below the divisor, so the difference sign bit decides the restore.
    assign rem_sh   = {hi, lo[WIDTH-1]};
    assign div_diff = rem_sh - {1'b0, opnd};
    assign fits     = ~div_diff[WIDTH];
    assign div_hi   = fits ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_lo   = {lo[WIDTH-2:0], fits};

    assign nxt_hi    = mode ? div_hi : mul_hi;
    assign nxt_lo    = mode ? div_lo : mul_lo;
    assign prod_next = {nxt_hi, nxt_lo};
    assign quot_next = nxt_lo;
    assign rem_next  = nxt_hi;
    assign last      = step && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
            cnt  <= '0;
        end else if (load) begin
            hi   <= '0;
            lo   <= mode ? a : b;
            opnd <= mode ? b : a;
            cnt  <= '0;
        end else if (step) begin
            hi   <= nxt_hi;
            lo   <= nxt_lo;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_calc_unit.sv
// ============================================================================
// seq_calc_unit: multi-cycle add/sub/mul/div engine with start/done handshake.
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_calc_unit
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [WIDTH-1:0]     remainder,
    output logic                 error
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e               state;
    logic                 load;
    logic                 step;
    logic                 mode;
    logic                 last;
    logic [2*WIDTH-1:0]   prod_next;
    logic [WIDTH-1:0]     quot_next;
    logic [WIDTH-1:0]     rem_next;
    logic [2*WIDTH-1:0]   a_ext;
    logic [2*WIDTH-1:0]   b_ext;

    assign a_ext = {{WIDTH{1'b0}}, a};
    assign b_ext = {{WIDTH{1'b0}}, b};
    assign busy  = (state != IDLE);
    assign done  = (state == DONE);

    assign load = (state == IDLE) && start &&
                  ((op == OP_MUL) || ((op == OP_DIV) && (b != '0)));
    assign step = (state == MUL) || (state == DIV);
    // op[0] separates MUL (10) from DIV (11) at load time
    assign mode = load ? op[0] : (state == DIV);

    calc_iter_unit #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .load      (load),
        .step      (step),
        .a         (a),
        .b         (b),
        .last      (last),
        .prod_next (prod_next),
        .quot_next (quot_next),
        .rem_next  (rem_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            result    <= '0;
            remainder <= '0;
            error     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        error <= 1'b0;
                        case (op)
                            OP_ADD: begin
                                result    <= a_ext + b_ext;
                                remainder <= '0;
                                state     <= DONE;
                            end
                            OP_SUB: begin
                                result    <= a_ext - b_ext;
                                remainder <= '0;
                                state     <= DONE;
                            end
                            OP_MUL: state <= MUL;
                            OP_DIV: begin
                                if (b == '0) begin
                                    result    <= '0;
                                    remainder <= '0;
                                    error     <= 1'b1;
                                    state     <= DONE;
                                end else begin
                                    state <= DIV;
                                end
                            end
                        endcase
                    end
                end
                MUL: begin
                    if (last) begin
                        result    <= prod_next;
                        remainder <= '0;
                        state     <= DONE;
                    end
                end
                DIV: begin
                    if (last) begin
                        result    <= {{WIDTH{1'b0}}, quot_next};
                        remainder <= rem_next;
                        state     <= DONE;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_calc_unit.sv
// ============================================================================
// tb_seq_calc_unit: scoreboard bench for seq_calc_unit at WIDTH=8 and WIDTH=16.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_calc_unit;

    typedef struct packed {
        logic [31:0] res;
        logic [15:0] rem;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [1:0]  op8, op16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        busy8, done8, err8;
    logic [15:0] res8;
    logic [7:0]  rem8;
    logic        busy16, done16, err16;
    logic [31:0] res16;
    logic [15:0] rem16;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    seq_calc_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .remainder(rem8), .error(err8)
    );

    seq_calc_unit #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(res16), .remainder(rem16), .error(err16)
    );

    function automatic exp_t model(input int w, input logic [1:0] op,
                                   input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        longint unsigned la, lb, mask;
        la   = 64'(a);
        lb   = 64'(b);
        mask = (64'd1 << (2 * w)) - 64'd1;
        e.res = '0; e.rem = '0; e.err = 1'b0; e.lat = 1;
        case (op)
            2'b00: e.res = 32'(la + lb);
            2'b01: e.res = 32'((la - lb) & mask);
            2'b10: begin e.res = 32'(la * lb); e.lat = w + 1; end
            default: begin
                if (lb == 0) e.err = 1'b1;
                else begin e.res = 32'(la / lb); e.rem = 16'(la % lb); e.lat = w + 1; end
            end
        endcase
        return e;
    endfunction

    // Issues one op, scrambles operands after the start edge, waits (bounded) for done.
    task automatic run_op(input bit w16, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, output int lat, output bit busy_ok,
                          output logic [31:0] res, output logic [15:0] rem, output logic err);
        int guard = 0;
        @(negedge clk);
        while ((w16 ? busy16 : busy8) && guard < 64) begin @(negedge clk); guard++; end
        if (w16) begin start16 = 1'b1; op16 = op; a16 = a; b16 = b; end
        else begin start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
        @(posedge clk); #1;
        lat = 1;
        busy_ok = w16 ? busy16 : busy8;
        while (!(w16 ? done16 : done8) && lat < 40) begin
            @(negedge clk);
            start8 = 1'b0; start16 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom);
            @(posedge clk); #1;
            lat++;
            if (!(w16 ? busy16 : busy8)) busy_ok = 1'b0;
        end
        res = w16 ? res16 : {16'h0, res8};
        rem = w16 ? rem16 : {8'h0, rem8};
        err = w16 ? err16 : err8;
        @(negedge clk);
        start8 = 1'b0; start16 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
        op8 = '0; op16 = '0; a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp += 6;
        if (busy8 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy8); end
        if (done8 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done8); end
        if (res8 !== 16'h0) begin n_bad++; $display("FAIL reset_result: got %h want 0", res8); end
        if (rem8 !== 8'h0) begin n_bad++; $display("FAIL reset_rem: got %h want 0", rem8); end
        if (err8 !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", err8); end
        if (busy16 !== 1'b0) begin n_bad++; $display("FAIL reset_busy16: got %b want 0", busy16); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_sub;
        logic [1:0]  ops [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
        logic [15:0] as  [4] = '{16'd200, 16'd5, 16'd255, 16'd10};
        logic [15:0] bs  [4] = '{16'd100, 16'd10, 16'd255, 16'd5};
        int lat; bit bok; logic [31:0] res; logic [15:0] rem; logic err; exp_t e;
        for (int i = 0; i < 4; i++) begin
            sb.push_back(model(8, ops[i], as[i], bs[i]));
            run_op(1'b0, ops[i], as[i], bs[i], lat, bok, res, rem, err);
            e = sb.pop_front();
            n_cmp += 4;
            if (lat != e.lat) begin n_bad++; $display("FAIL addsub_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
            if (res !== e.res) begin n_bad++; $display("FAIL addsub_res[%0d]: got %h want %h", i, res, e.res); end
            if (rem !== e.rem) begin n_bad++; $display("FAIL addsub_rem[%0d]: got %h want %h", i, rem, e.rem); end
            if (err !== e.err) begin n_bad++; $display("FAIL addsub_err[%0d]: got %b want %b", i, err, e.err); end
        end
    endtask

    task automatic test_mul;
        int lat; bit bok; logic [31:0] res; logic [15:0] rem; logic err; exp_t e;
        sb.push_back(model(8, 2'b10, 16'd255, 16'd255));
        run_op(1'b0, 2'b10, 16'd255, 16'd255, lat, bok, res, rem, err);
        e = sb.pop_front();
        n_cmp += 4;
        if (lat != e.lat) begin n_bad++; $display("FAIL mul_lat: got %0d want %0d", lat, e.lat); end
        if (res !== e.res) begin n_bad++; $display("FAIL mul_res: got %h want %h", res, e.res); end
        if (bok !== 1'b1) begin n_bad++; $display("FAIL mul_busy: got %b want 1", bok); end
        if (rem !== e.rem || err !== e.err) begin
            n_bad++; $display("FAIL mul_rem_err: got %h/%b want %h/%b", rem, err, e.rem, e.err);
        end
    endtask

    task automatic test_div;
        logic [15:0] as [2] = '{16'd200, 16'd9};
        logic [15:0] bs [2] = '{16'd7, 16'd0};
        int lat; bit bok; logic [31:0] res; logic [15:0] rem; logic err; exp_t e;
        for (int i = 0; i < 2; i++) begin
            sb.push_back(model(8, 2'b11, as[i], bs[i]));
            run_op(1'b0, 2'b11, as[i], bs[i], lat, bok, res, rem, err);
            e = sb.pop_front();
            n_cmp += 4;
            if (lat != e.lat) begin n_bad++; $display("FAIL div_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
            if (res !== e.res) begin n_bad++; $display("FAIL div_res[%0d]: got %h want %h", i, res, e.res); end
            if (rem !== e.rem) begin n_bad++; $display("FAIL div_rem[%0d]: got %h want %h", i, rem, e.rem); end
            if (err !== e.err) begin n_bad++; $display("FAIL div_err[%0d]: got %b want %b", i, err, e.err); end
        end
    endtask

    task automatic test_hold_start;
        exp_t e; int dcount = 0; int dseen = -1; int guard = 0; logic [15:0] got = '0;
        @(negedge clk);
        while (busy8 && guard < 64) begin @(negedge clk); guard++; end
        sb.push_back(model(8, 2'b10, 16'd13, 16'd11));
        start8 = 1'b1; op8 = 2'b10; a8 = 8'd13; b8 = 8'd11;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (done8) begin dcount++; got = res8; if (dseen < 0) dseen = i; end
            @(negedge clk);
            if (dseen >= 0 && i >= dseen + 1) start8 = 1'b0;
            else begin a8 = ~a8; b8 = ~b8; end
        end
        e = sb.pop_front();
        n_cmp += 4;
        if (dcount != 1) begin n_bad++; $display("FAIL hold_done_count: got %0d want 1", dcount); end
        if (dseen + 1 != e.lat) begin n_bad++; $display("FAIL hold_lat: got %0d want %0d", dseen + 1, e.lat); end
        if ({16'h0, got} !== e.res) begin n_bad++; $display("FAIL hold_res: got %h want %h", got, e.res); end
        if (busy8 !== 1'b0) begin n_bad++; $display("FAIL hold_busy_after: got %b want 0", busy8); end
    endtask

    task automatic test_reset_mid;
        int dc = 0; int guard = 0;
        int lat; bit bok; logic [31:0] res; logic [15:0] rem; logic err; exp_t e;
        @(negedge clk);
        while (busy8 && guard < 64) begin @(negedge clk); guard++; end
        start8 = 1'b1; op8 = 2'b11; a8 = 8'd100; b8 = 8'd3;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp += 3;
        if (busy8 !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy8); end
        if (done8 !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b want 0", done8); end
        if (res8 !== 16'h0) begin n_bad++; $display("FAIL rstmid_result: got %h want 0", res8); end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin @(posedge clk); #1; if (done8) dc++; end
        n_cmp++;
        if (dc != 0) begin n_bad++; $display("FAIL rstmid_spurious_done: got %0d want 0", dc); end
        sb.push_back(model(8, 2'b00, 16'd1, 16'd1));
        run_op(1'b0, 2'b00, 16'd1, 16'd1, lat, bok, res, rem, err);
        e = sb.pop_front();
        n_cmp += 2;
        if (res !== e.res) begin n_bad++; $display("FAIL rstmid_add_res: got %h want %h", res, e.res); end
        if (lat != e.lat) begin n_bad++; $display("FAIL rstmid_add_lat: got %0d want %0d", lat, e.lat); end
    endtask

    task automatic test_random;
        int lat; bit bok; logic [31:0] res; logic [15:0] rem; logic err; exp_t e;
        logic [1:0] op; logic [15:0] a, b;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 12; i++) begin
                op = (i % 2 == 1) ? 2'b11 : 2'b10;
                a  = (k == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
                b  = (k == 1) ? 16'($urandom) : 16'($urandom_range(0, 255));
                if (i == 7) b = '0;
                sb.push_back(model((k == 1) ? 16 : 8, op, a, b));
                run_op(k == 1, op, a, b, lat, bok, res, rem, err);
                e = sb.pop_front();
                n_cmp += 4;
                if (lat != e.lat) begin n_bad++; $display("FAIL rand_lat[w%0d.%0d]: got %0d want %0d", k, i, lat, e.lat); end
                if (res !== e.res) begin n_bad++; $display("FAIL rand_res[w%0d.%0d]: got %h want %h", k, i, res, e.res); end
                if (rem !== e.rem) begin n_bad++; $display("FAIL rand_rem[w%0d.%0d]: got %h want %h", k, i, rem, e.rem); end
                if (err !== e.err) begin n_bad++; $display("FAIL rand_err[w%0d.%0d]: got %b want %b", k, i, err, e.err); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_hold_start();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
